bus_arbiter: RTL

Round-robin arbiter for the shared data bus of the four-core MIPS32 system. It takes the data-memory requests of arbitration modules 0–3 and grants the bus to one master at a time. It drives the granted master's read, write, address and data onto the `Bus_arbiter_DataMem_*` lines, and holds that grant until the memory system returns Ready or a timeout expires. Each arbitration module uses its one-hot grant to qualify the Ready and data that the bus broadcasts to all masters.

---
 rtl/bus_arbiter_if.sv | 58 +++++
 rtl/bus_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_if.sv
// Shared data-bus bundle between the four arbitration modules and the bus
// arbiter. The arbiter takes the slave view. The request side takes the master view.
// Handshake: a master requests by holding Read or any Write enable high.
// It owns the bus while its Grant is high. The transfer completes on the
// first GRANT cycle in which Bus_arbiter_DataMem_Ready is sampled high.
interface bus_arbiter_if;
  logic        Arb_M_0_DataMem_Read;
  logic [3:0]  Arb_M_0_DataMem_Write;
  logic [29:0] Arb_M_0_DataMem_Address;
  logic [31:0] Arb_M_0_DataMem_Out;
  logic        Arb_M_1_DataMem_Read;
  logic [3:0]  Arb_M_1_DataMem_Write;
  logic [29:0] Arb_M_1_DataMem_Address;
  logic [31:0] Arb_M_1_DataMem_Out;
  logic        Arb_M_2_DataMem_Read;
  logic [3:0]  Arb_M_2_DataMem_Write;
  logic [29:0] Arb_M_2_DataMem_Address;
  logic [31:0] Arb_M_2_DataMem_Out;
  logic        Arb_M_3_DataMem_Read;
  logic [3:0]  Arb_M_3_DataMem_Write;
  logic [29:0] Arb_M_3_DataMem_Address;
  logic [31:0] Arb_M_3_DataMem_Out;
  logic        Bus_arbiter_DataMem_Ready;
  logic        Bus_arbiter_DataMem_Read;
  logic [3:0]  Bus_arbiter_DataMem_Write;
  logic [29:0] Bus_arbiter_DataMem_Address;
  logic [31:0] Bus_arbiter_DataMem_Out;
  logic        Arb_M_0_Grant;
  logic        Arb_M_1_Grant;
  logic        Arb_M_2_Grant;
  logic        Arb_M_3_Grant;
  logic        Timeout_Error;
  logic [1:0]  Timeout_Master;

  modport slave (
    input  Arb_M_0_DataMem_Read, Arb_M_0_DataMem_Write, Arb_M_0_DataMem_Address, Arb_M_0_DataMem_Out,
    input  Arb_M_1_DataMem_Read, Arb_M_1_DataMem_Write, Arb_M_1_DataMem_Address, Arb_M_1_DataMem_Out,
    input  Arb_M_2_DataMem_Read, Arb_M_2_DataMem_Write, Arb_M_2_DataMem_Address, Arb_M_2_DataMem_Out,
    input  Arb_M_3_DataMem_Read, Arb_M_3_DataMem_Write, Arb_M_3_DataMem_Address, Arb_M_3_DataMem_Out,
    input  Bus_arbiter_DataMem_Ready,
    output Bus_arbiter_DataMem_Read, Bus_arbiter_DataMem_Write,
    output Bus_arbiter_DataMem_Address, Bus_arbiter_DataMem_Out,
    output Arb_M_0_Grant, Arb_M_1_Grant, Arb_M_2_Grant, Arb_M_3_Grant,
    output Timeout_Error, Timeout_Master
  );

  modport master (
    output Arb_M_0_DataMem_Read, Arb_M_0_DataMem_Write, Arb_M_0_DataMem_Address, Arb_M_0_DataMem_Out,
    output Arb_M_1_DataMem_Read, Arb_M_1_DataMem_Write, Arb_M_1_DataMem_Address, Arb_M_1_DataMem_Out,
    output Arb_M_2_DataMem_Read, Arb_M_2_DataMem_Write, Arb_M_2_DataMem_Address, Arb_M_2_DataMem_Out,
    output Arb_M_3_DataMem_Read, Arb_M_3_DataMem_Write, Arb_M_3_DataMem_Address, Arb_M_3_DataMem_Out,
    output Bus_arbiter_DataMem_Ready,
    input  Bus_arbiter_DataMem_Read, Bus_arbiter_DataMem_Write,
    input  Bus_arbiter_DataMem_Address, Bus_arbiter_DataMem_Out,
    input  Arb_M_0_Grant, Arb_M_1_Grant, Arb_M_2_Grant, Arb_M_3_Grant,
    input  Timeout_Error, Timeout_Master
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the four-core shared data bus. It grants one master
// at a time and muxes that master onto the bus. It holds the grant until Ready,
// a master abort or a timeout, then inserts one idle RELEASE cycle.
module bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  bus_arbiter_if.slave bus,
  output logic [1:0]  dbg_state_o,
  output logic [1:0]  dbg_rr_ptr_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         grant_q, grant_d;
  logic [1:0]         rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               terr_q, terr_d;
  logic [1:0]         tmaster_q, tmaster_d;

  logic               rd_a   [4];
  logic [3:0]         wr_a   [4];
  logic [29:0]        addr_a [4];
  logic [31:0]        dout_a [4];
  logic [3:0]         req;
  logic [1:0]         winner;
  logic [1:0]         pick;
  logic               pick_valid;

  assign rd_a[0]   = bus.Arb_M_0_DataMem_Read;
  assign rd_a[1]   = bus.Arb_M_1_DataMem_Read;
  assign rd_a[2]   = bus.Arb_M_2_DataMem_Read;
  assign rd_a[3]   = bus.Arb_M_3_DataMem_Read;
  assign wr_a[0]   = bus.Arb_M_0_DataMem_Write;
  assign wr_a[1]   = bus.Arb_M_1_DataMem_Write;
  assign wr_a[2]   = bus.Arb_M_2_DataMem_Write;
  assign wr_a[3]   = bus.Arb_M_3_DataMem_Write;
  assign addr_a[0] = bus.Arb_M_0_DataMem_Address;
  assign addr_a[1] = bus.Arb_M_1_DataMem_Address;
  assign addr_a[2] = bus.Arb_M_2_DataMem_Address;
  assign addr_a[3] = bus.Arb_M_3_DataMem_Address;
  assign dout_a[0] = bus.Arb_M_0_DataMem_Out;
  assign dout_a[1] = bus.Arb_M_1_DataMem_Out;
  assign dout_a[2] = bus.Arb_M_2_DataMem_Out;
  assign dout_a[3] = bus.Arb_M_3_DataMem_Out;

  // A master is requesting when it reads or enables any write byte.
  always_comb begin
    for (int i = 0; i < 4; i++) req[i] = rd_a[i] | (|wr_a[i]);
  end

  // Encode the current one-hot grant into the owning master's index.
  always_comb begin
    winner = 2'd0;
    for (int i = 0; i < 4; i++) if (grant_q[i]) winner = 2'(i);
  end

  // Round-robin search: first requester at or after rr_ptr, wrapping mod 4.
  always_comb begin
    logic [1:0] idx;
    pick       = 2'd0;
    pick_valid = 1'b0;
    idx        = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr_q + 2'(k);
      if (!pick_valid && req[idx]) begin
        pick       = idx;
        pick_valid = 1'b1;
      end
    end
  end

  // Next-state logic for arbitration, completion, abort and timeout.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    count_d   = count_q;
    terr_d    = 1'b0;
    tmaster_d = tmaster_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = 4'b0001 << pick;
          count_d = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (bus.Bus_arbiter_DataMem_Ready || !req[winner]) begin
          grant_d  = 4'b0000;
          rr_ptr_d = winner + 2'd1;
          state_d  = RELEASE;
        end else if (count_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          grant_d   = 4'b0000;
          rr_ptr_d  = winner + 2'd1;
          terr_d    = 1'b1;
          tmaster_d = winner;
          state_d   = RELEASE;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      RELEASE: begin
        grant_d = 4'b0000;
        state_d = IDLE;
      end
      default: begin
        grant_d = 4'b0000;
        state_d = IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      grant_q   <= 4'b0000;
      rr_ptr_q  <= 2'd0;
      count_q   <= '0;
      terr_q    <= 1'b0;
      tmaster_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      count_q   <= count_d;
      terr_q    <= terr_d;
      tmaster_q <= tmaster_d;
    end
  end

  // Bus mux: AND-OR of the granted master's inputs. The grant is zero
  // outside GRANT, which keeps the bus quiet in IDLE, RELEASE and reset.
  always_comb begin
    bus.Bus_arbiter_DataMem_Read    = 1'b0;
    bus.Bus_arbiter_DataMem_Write   = 4'b0000;
    bus.Bus_arbiter_DataMem_Address = 30'd0;
    bus.Bus_arbiter_DataMem_Out     = 32'd0;
    for (int i = 0; i < 4; i++) begin
      if (grant_q[i] && (state_q == GRANT)) begin
        bus.Bus_arbiter_DataMem_Read    = bus.Bus_arbiter_DataMem_Read    | rd_a[i];
        bus.Bus_arbiter_DataMem_Write   = bus.Bus_arbiter_DataMem_Write   | wr_a[i];
        bus.Bus_arbiter_DataMem_Address = bus.Bus_arbiter_DataMem_Address | addr_a[i];
        bus.Bus_arbiter_DataMem_Out     = bus.Bus_arbiter_DataMem_Out     | dout_a[i];
      end
    end
  end

  assign bus.Arb_M_0_Grant  = grant_q[0];
  assign bus.Arb_M_1_Grant  = grant_q[1];
  assign bus.Arb_M_2_Grant  = grant_q[2];
  assign bus.Arb_M_3_Grant  = grant_q[3];
  assign bus.Timeout_Error  = terr_q;
  assign bus.Timeout_Master = tmaster_q;
  assign dbg_state_o        = state_q;
  assign dbg_rr_ptr_o       = rr_ptr_q;

endmodule
